// File: rtl/alu_request_arbiter_if.sv
// alu_request_arbiter_if: two ALU request ports plus the shared result port
`timescale 1ns/1ps
interface alu_request_arbiter_if #(parameter int WIDTH = 4);
  logic valid_a, ready_a, valid_b, ready_b;
  logic [2:0] opcode_a, opcode_b;
  logic [WIDTH-1:0] first_a, second_a, first_b, second_b;
  logic result_valid, result_ready, result_id, carry, zero, error;
  logic [WIDTH-1:0] result;
  modport master (
    output valid_a, opcode_a, first_a, second_a,
    output valid_b, opcode_b, first_b, second_b, result_ready,
    input  ready_a, ready_b, result_valid, result, result_id, carry, zero, error
  );
  modport slave (
    input  valid_a, opcode_a, first_a, second_a,
    input  valid_b, opcode_b, first_b, second_b, result_ready,
    output ready_a, ready_b, result_valid, result, result_id, carry, zero, error
  );
endinterface

// File: rtl/alu_request_arbiter.sv
// alu_request_arbiter: round-robin sharing of one ALU between two requesters
`timescale 1ns/1ps
module alu_request_arbiter #(parameter int WIDTH = 4) (
  input logic clk,
  input logic rst,
  alu_request_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state, state_nxt;
  logic last_grant, grant_b, id_q, carry_c, err_c;
  logic [2:0] op_q;
  logic [WIDTH-1:0] f_q, s_q, res_c;
  logic [WIDTH:0] sum, diff;
  assign grant_b = bus.valid_b && (!bus.valid_a || !last_grant);
  // Ready is gated by rst so it drops the instant reset asserts
  assign bus.ready_a = !rst && state == IDLE && bus.valid_a && !grant_b;
  assign bus.ready_b = !rst && state == IDLE && grant_b;
  assign sum = {1'b0, f_q} + {1'b0, s_q};
  assign diff = {1'b0, f_q} - {1'b0, s_q};
  always_comb begin
    res_c = op_q == 3'd0 ? f_q & s_q :
            op_q == 3'd1 ? f_q | s_q :
            op_q == 3'd2 ? f_q ^ s_q :
            op_q == 3'd3 ? sum[WIDTH-1:0] :
            op_q == 3'd4 ? diff[WIDTH-1:0] :
            op_q == 3'd5 ? ~f_q : '0;
    carry_c = op_q == 3'd3 ? sum[WIDTH] : op_q == 3'd4 ? diff[WIDTH] : 1'b0;
    err_c = op_q[2] & op_q[1];
  end
  always_comb begin
    state_nxt = state;
    if (state == IDLE && (bus.ready_a || bus.ready_b)) state_nxt = EXEC;
    else if (state == EXEC) state_nxt = DONE;
    else if (state == DONE && bus.result_ready) state_nxt = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last_grant <= 1'b1;
      id_q <= 1'b0;
      op_q <= '0;
      f_q <= '0;
      s_q <= '0;
      bus.result_valid <= 1'b0;
      bus.result <= '0;
      bus.result_id <= 1'b0;
      bus.carry <= 1'b0;
      bus.zero <= 1'b0;
      bus.error <= 1'b0;
    end else begin
      state <= state_nxt;
      if (bus.ready_a || bus.ready_b) begin
        op_q <= bus.ready_b ? bus.opcode_b : bus.opcode_a;
        f_q <= bus.ready_b ? bus.first_b : bus.first_a;
        s_q <= bus.ready_b ? bus.second_b : bus.second_a;
        id_q <= bus.ready_b;
        last_grant <= bus.ready_b;
      end
      if (state == EXEC) begin
        bus.result_valid <= 1'b1;
        bus.result <= res_c;
        bus.result_id <= id_q;
        bus.carry <= carry_c;
        bus.zero <= res_c == '0;
        bus.error <= err_c;
      end
      if (state == DONE && bus.result_ready) bus.result_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_request_arbiter.sv
// tb_alu_request_arbiter: directed scenarios with hand-computed expectations
`timescale 1ns/1ps
module tb_alu_request_arbiter;
  logic clk, rst;
  int passed = 0, total = 0;
  alu_request_arbiter_if #(.WIDTH(4)) bus();
  alu_request_arbiter #(.WIDTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic [8:0] outs;
  assign outs = {bus.result_valid, bus.result_id, bus.result, bus.carry, bus.zero, bus.error};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end
  task automatic idle_inputs();
    bus.valid_a = 0; bus.opcode_a = 0; bus.first_a = 0; bus.second_a = 0;
    bus.valid_b = 0; bus.opcode_b = 0; bus.first_b = 0; bus.second_b = 0;
    bus.result_ready = 0;
  endtask
  task automatic run_a(input logic [2:0] op, input logic [3:0] f, input logic [3:0] s);
    bus.valid_a = 1; bus.opcode_a = op; bus.first_a = f; bus.second_a = s;
    @(posedge clk); #1;
    bus.valid_a = 0; bus.opcode_a = 3'b000; bus.first_a = ~f; bus.second_a = ~s;
    @(posedge clk); #1;
  endtask
  task automatic release_result();
    bus.result_ready = 1;
    @(posedge clk); #1;
    bus.result_ready = 0;
  endtask
  task automatic test_reset();
    total++; if (outs !== 9'b0) $display("FAIL reset_state: got %b want %b", outs, 9'b0); else passed++;
    run_a(3'b001, 4'b0101, 4'b0011);
    bus.valid_a = 1;
    #2 rst = 1;
    #1;
    total++; if (outs !== 9'b0) $display("FAIL async_reset_outs: got %b want %b", outs, 9'b0); else passed++;
    total++; if (bus.ready_a !== 1'b0) $display("FAIL async_reset_ready: got %b want 0", bus.ready_a); else passed++;
    #2 rst = 0;
    #1;
    total++; if ({bus.ready_a, bus.ready_b} !== 2'b10) $display("FAIL post_reset_grant: got %b want 10", {bus.ready_a, bus.ready_b}); else passed++;
    bus.valid_a = 0;
    @(posedge clk); #1;
    total++; if (outs !== 9'b0) $display("FAIL dropped_valid: got %b want %b", outs, 9'b0); else passed++;
  endtask
  task automatic test_or();
    bus.valid_a = 1; bus.opcode_a = 3'b001; bus.first_a = 4'b0101; bus.second_a = 4'b0011;
    @(posedge clk); #1;
    bus.valid_a = 0; bus.first_a = 4'b0000;
    total++; if (outs[8] !== 1'b0) $display("FAIL or_exec_cycle: got %b want 0", outs[8]); else passed++;
    total++; if ({bus.ready_a, bus.ready_b} !== 2'b00) $display("FAIL or_exec_ready: got %b want 00", {bus.ready_a, bus.ready_b}); else passed++;
    @(posedge clk); #1;
    total++; if (outs !== {1'b1, 1'b0, 4'b0111, 3'b000}) $display("FAIL or_result: got %b want %b", outs, {1'b1, 1'b0, 4'b0111, 3'b000}); else passed++;
    release_result();
    total++; if (outs !== {1'b0, 1'b0, 4'b0111, 3'b000}) $display("FAIL or_release: got %b want %b", outs, {1'b0, 1'b0, 4'b0111, 3'b000}); else passed++;
  endtask
  task automatic test_round_robin();
    rst = 1; #1 rst = 0;
    bus.valid_a = 1; bus.opcode_a = 3'b000; bus.first_a = 4'b1100; bus.second_a = 4'b1010;
    bus.valid_b = 1; bus.opcode_b = 3'b011; bus.first_b = 4'b0011; bus.second_b = 4'b0100;
    bus.result_ready = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++; if ({bus.ready_a, bus.ready_b} !== (k % 2 == 1 ? 2'b01 : 2'b10)) $display("FAIL rr_grant%0d: got %b want %b", k, {bus.ready_a, bus.ready_b}, (k % 2 == 1 ? 2'b01 : 2'b10)); else passed++;
      @(posedge clk); @(posedge clk); #1;
      total++; if (outs !== (k % 2 == 1 ? {1'b1, 1'b1, 4'b0111, 3'b000} : {1'b1, 1'b0, 4'b1000, 3'b000})) $display("FAIL rr_result%0d: got %b want %b", k, outs, (k % 2 == 1 ? {1'b1, 1'b1, 4'b0111, 3'b000} : {1'b1, 1'b0, 4'b1000, 3'b000})); else passed++;
      @(posedge clk); #1;
    end
    bus.valid_a = 0; bus.valid_b = 0; bus.result_ready = 0;
  endtask
  task automatic test_arith();
    run_a(3'b011, 4'b1111, 4'b0001);
    total++; if (outs !== {1'b1, 1'b0, 4'b0000, 3'b110}) $display("FAIL add_carry: got %b want %b", outs, {1'b1, 1'b0, 4'b0000, 3'b110}); else passed++;
    release_result();
    run_a(3'b100, 4'b0010, 4'b0011);
    total++; if (outs !== {1'b1, 1'b0, 4'b1111, 3'b100}) $display("FAIL sub_borrow: got %b want %b", outs, {1'b1, 1'b0, 4'b1111, 3'b100}); else passed++;
    release_result();
    run_a(3'b010, 4'b1010, 4'b1010);
    total++; if (outs !== {1'b1, 1'b0, 4'b0000, 3'b010}) $display("FAIL xor_zero: got %b want %b", outs, {1'b1, 1'b0, 4'b0000, 3'b010}); else passed++;
    release_result();
    run_a(3'b101, 4'b0110, 4'b1111);
    total++; if (outs !== {1'b1, 1'b0, 4'b1001, 3'b000}) $display("FAIL not_first: got %b want %b", outs, {1'b1, 1'b0, 4'b1001, 3'b000}); else passed++;
    release_result();
  endtask
  task automatic test_backpressure();
    run_a(3'b011, 4'b0011, 4'b0101);
    bus.valid_a = 1; bus.valid_b = 1;
    for (int k = 0; k < 5; k++) begin
      total++; if ({bus.ready_a, bus.ready_b} !== 2'b00) $display("FAIL bp_ready%0d: got %b want 00", k, {bus.ready_a, bus.ready_b}); else passed++;
      total++; if (outs !== {1'b1, 1'b0, 4'b1000, 3'b000}) $display("FAIL bp_hold%0d: got %b want %b", k, outs, {1'b1, 1'b0, 4'b1000, 3'b000}); else passed++;
      @(posedge clk); #1;
    end
    bus.valid_a = 0; bus.valid_b = 0;
    release_result();
    total++; if (outs !== {1'b0, 1'b0, 4'b1000, 3'b000}) $display("FAIL bp_release: got %b want %b", outs, {1'b0, 1'b0, 4'b1000, 3'b000}); else passed++;
    run_a(3'b110, 4'b0101, 4'b0011);
    total++; if (outs !== {1'b1, 1'b0, 4'b0000, 3'b011}) $display("FAIL illegal_op: got %b want %b", outs, {1'b1, 1'b0, 4'b0000, 3'b011}); else passed++;
    release_result();
    bus.result_ready = 1;
    @(posedge clk); @(posedge clk); #1;
    bus.result_ready = 0;
    total++; if (outs !== {1'b0, 1'b0, 4'b0000, 3'b011}) $display("FAIL idle_ready_noeffect: got %b want %b", outs, {1'b0, 1'b0, 4'b0000, 3'b011}); else passed++;
  endtask
  task automatic test_reset_mid_op();
    bus.valid_b = 1; bus.opcode_b = 3'b011; bus.first_b = 4'b0001; bus.second_b = 4'b0001;
    @(posedge clk); #1;
    bus.valid_b = 0;
    rst = 1; #1 rst = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      total++; if (outs !== 9'b0) $display("FAIL discard%0d: got %b want %b", k, outs, 9'b0); else passed++;
    end
    bus.valid_a = 1; bus.opcode_a = 3'b000; bus.first_a = 4'b1111; bus.second_a = 4'b0110;
    bus.valid_b = 1; bus.opcode_b = 3'b001; bus.first_b = 4'b0001; bus.second_b = 4'b0010;
    #1;
    total++; if ({bus.ready_a, bus.ready_b} !== 2'b10) $display("FAIL tie_after_reset: got %b want 10", {bus.ready_a, bus.ready_b}); else passed++;
    @(posedge clk); #1;
    bus.valid_a = 0; bus.valid_b = 0;
    @(posedge clk); #1;
    total++; if (outs !== {1'b1, 1'b0, 4'b0110, 3'b000}) $display("FAIL after_reset_op: got %b want %b", outs, {1'b1, 1'b0, 4'b0110, 3'b000}); else passed++;
    release_result();
  endtask
  initial begin
    rst = 1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    test_reset();
    test_or();
    test_round_robin();
    test_arith();
    test_backpressure();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
